// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or insert a bubble.
// A bubble clears valid and forces a NOP but leaves pc/pc4 at their previous values.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc4_i,
  input  logic [31:0]     inst_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic [31:0]     inst_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [31:0]     inst_q, inst_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    inst_d  = inst_q;
    if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      pc4_d   = pc4_i;
      inst_d  = inst_i;
    end else if (bubble_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= XLEN'(4);
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, RUN/HALT FSM, imem request and IF/ID loading.
// Define FETCH_PERF_CNT_EN to add the perf_fetched_o / perf_stall_o counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic [31:0]     if_id_inst_o,
  output logic            halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_stall_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            load;
  logic            bubble;

  assign pc_plus4 = pc_q + XLEN'(4);

  // Priority in RUN: redirect > halt > stall > fetch; a redirect flushes the younger halting instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect_i) begin
          pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
          bubble = 1'b1;
        end else if (halt_i) begin
          state_d = ST_HALT;
          bubble  = 1'b1;
        end else if (stall_i) begin
          // hold PC and IF/ID; this cycle's fetch data is dropped
        end else if (imem_ready_i) begin
          pc_d = pc_plus4;
          load = 1'b1;
        end else begin
          bubble = 1'b1;
        end
      end
      ST_HALT: bubble = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_req_o  = (state_q == ST_RUN);
  assign imem_addr_o = pc_q;
  assign halted_o    = (state_q == ST_HALT);

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .bubble_i (bubble),
    .pc_i     (pc_q),
    .pc4_i    (pc_plus4),
    .inst_i   (imem_rdata_i),
    .valid_o  (if_id_valid_o),
    .pc_o     (if_id_pc_o),
    .pc4_o    (if_id_pc4_o),
    .inst_o   (if_id_inst_o)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Both counters only move in RUN, so they freeze once halted.
  always_comb begin
    perf_fetched_d = perf_fetched_q + (load ? 32'd1 : 32'd0);
    perf_stall_d   = perf_stall_q;
    if (state_q == ST_RUN && !redirect_i && (stall_i || !imem_ready_i))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; instruction memory is a fixed address hash.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halt_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b1;
  logic [31:0] imem_rdata_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_inst_o;
  logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_stall_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0] ^ 24'hC0FFEE, 8'h33};
  endfunction

  assign imem_rdata_i = mem_word(imem_addr_o);

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_inst_o  (if_id_inst_o),
    .halted_o      (halted_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o(perf_fetched_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall_i = 0; redirect_i = 0; halt_i = 0; imem_ready_i = 1; redirect_pc_i = '0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o} !== {1'b0, 32'h0, 32'h4, NOP}) begin
      bad++;
      $display("FAIL reset_ifid: got v=%b pc=%h pc4=%h inst=%h want v=0 pc=0 pc4=4 inst=%h",
               if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o, NOP);
    end
    total++;
    if ({imem_req_o, imem_addr_o, halted_o} !== {1'b1, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_ctrl: got req=%b addr=%h halted=%b want req=1 addr=0 halted=0",
               imem_req_o, imem_addr_o, halted_o);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      step();
      total++;
      if ({if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o, imem_addr_o} !==
          {1'b1, exp_pc, exp_pc + 32'd4, mem_word(exp_pc), exp_pc + 32'd4}) begin
        bad++;
        $display("FAIL seq_%0d: got v=%b pc=%h pc4=%h inst=%h addr=%h want pc=%h inst=%h",
                 i, if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o, imem_addr_o,
                 exp_pc, mem_word(exp_pc));
      end
    end
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (perf_fetched_o !== 32'd4) begin
      bad++;
      $display("FAIL perf_fetched: got %0d want 4", perf_fetched_o);
    end
`endif
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    stall_i = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({if_id_valid_o, if_id_pc_o, if_id_inst_o, imem_addr_o} !==
          {1'b1, 32'h4, mem_word(32'h4), 32'h8}) begin
        bad++;
        $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h addr=%h want v=1 pc=4 addr=8",
                 i, if_id_valid_o, if_id_pc_o, if_id_inst_o, imem_addr_o);
      end
    end
    stall_i = 0;
    step();
    total++;
    if ({if_id_valid_o, if_id_pc_o, if_id_inst_o} !== {1'b1, 32'h8, mem_word(32'h8)}) begin
      bad++;
      $display("FAIL stall_resume: got v=%b pc=%h inst=%h want v=1 pc=8",
               if_id_valid_o, if_id_pc_o, if_id_inst_o);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step();
    redirect_i = 1; redirect_pc_i = 32'h103; stall_i = 1; halt_i = 1;
    step();
    redirect_i = 0; stall_i = 0; halt_i = 0;
    total++;
    if ({imem_addr_o, imem_req_o, halted_o, if_id_valid_o, if_id_inst_o, if_id_pc_o} !==
        {32'h100, 1'b1, 1'b0, 1'b0, NOP, 32'h0}) begin
      bad++;
      $display("FAIL redirect_bubble: got addr=%h req=%b halted=%b v=%b inst=%h pc=%h want addr=100 req=1 halted=0 v=0 inst=13 pc=0",
               imem_addr_o, imem_req_o, halted_o, if_id_valid_o, if_id_inst_o, if_id_pc_o);
    end
    step();
    total++;
    if ({if_id_valid_o, if_id_pc_o, if_id_inst_o, imem_addr_o} !==
        {1'b1, 32'h100, mem_word(32'h100), 32'h104}) begin
      bad++;
      $display("FAIL redirect_target: got v=%b pc=%h inst=%h addr=%h want v=1 pc=100 addr=104",
               if_id_valid_o, if_id_pc_o, if_id_inst_o, imem_addr_o);
    end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (4) step();
    halt_i = 1;
    step();
    halt_i = 0;
    total++;
    if ({halted_o, imem_req_o, if_id_valid_o, if_id_inst_o, if_id_pc_o} !==
        {1'b1, 1'b0, 1'b0, NOP, 32'hC}) begin
      bad++;
      $display("FAIL halt_enter: got halted=%b req=%b v=%b inst=%h pc=%h want halted=1 req=0 v=0 inst=13 pc=c",
               halted_o, imem_req_o, if_id_valid_o, if_id_inst_o, if_id_pc_o);
    end
    redirect_i = 1; redirect_pc_i = 32'h40;
    step();
    step();
    redirect_i = 0;
    total++;
    if ({halted_o, imem_req_o, imem_addr_o, if_id_valid_o} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
      bad++;
      $display("FAIL halt_ignore_redirect: got halted=%b req=%b addr=%h v=%b want halted=1 req=0 addr=10 v=0",
               halted_o, imem_req_o, imem_addr_o, if_id_valid_o);
    end
    #3 rst_n = 0;
    #1;
    total++;
    if ({halted_o, imem_req_o, imem_addr_o, if_id_valid_o, if_id_pc_o, if_id_pc4_o} !==
        {1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h4}) begin
      bad++;
      $display("FAIL halt_async_reset: got halted=%b req=%b addr=%h v=%b pc=%h pc4=%h want halted=0 req=1 addr=0 v=0 pc=0 pc4=4",
               halted_o, imem_req_o, imem_addr_o, if_id_valid_o, if_id_pc_o, if_id_pc4_o);
    end
  endtask

  task automatic test_not_ready();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_base;
`endif
    do_reset();
    repeat (8) step();
`ifdef FETCH_PERF_CNT_EN
    stall_base = perf_stall_o;
`endif
    imem_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({if_id_valid_o, if_id_inst_o, if_id_pc_o, imem_addr_o} !==
          {1'b0, NOP, 32'h1C, 32'h20}) begin
        bad++;
        $display("FAIL not_ready_bubble_%0d: got v=%b inst=%h pc=%h addr=%h want v=0 inst=13 pc=1c addr=20",
                 i, if_id_valid_o, if_id_inst_o, if_id_pc_o, imem_addr_o);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (perf_stall_o - stall_base !== 32'd3) begin
      bad++;
      $display("FAIL perf_stall: got delta %0d want 3", perf_stall_o - stall_base);
    end
`endif
    imem_ready_i = 1;
    step();
    total++;
    if ({if_id_valid_o, if_id_pc_o, imem_addr_o} !== {1'b1, 32'h20, 32'h24}) begin
      bad++;
      $display("FAIL not_ready_resume: got v=%b pc=%h addr=%h want v=1 pc=20 addr=24",
               if_id_valid_o, if_id_pc_o, imem_addr_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFF;
    step();
    redirect_i = 0;
    total++;
    if (imem_addr_o !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_align: got addr=%h want fffffffc", imem_addr_o);
    end
    step();
    total++;
    if ({if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o, imem_addr_o} !==
        {1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 32'h0}) begin
      bad++;
      $display("FAIL wrap_pc4: got v=%b pc=%h pc4=%h inst=%h addr=%h want v=1 pc=fffffffc pc4=0 addr=0",
               if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o, imem_addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_not_ready();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32 core: owns the program counter, issues fetch requests to instruction memory, and loads the IF/ID pipeline register. Decode reads `if_id_inst_o[6:2]` as the 5-bit opcode field feeding the control decoder. The block also absorbs stall, redirect and halt requests from later stages.

## Interface
- `XLEN`, 32: datapath width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall_i` input 1: load-use stall from hazard unit; holds PC and IF/ID.
- `redirect_i` input 1: taken branch/jal/jalr resolved in EX.
- `redirect_pc_i` input XLEN: redirect target.
- `halt_i` input 1: halt decoded in ID (ecall/ebreak/fence).
- `imem_req_o` output 1: fetch request.
- `imem_addr_o` output XLEN: fetch address (= PC).
- `imem_ready_i` input 1: `imem_rdata_i` valid this cycle.
- `imem_rdata_i` input 32: fetched instruction.
- `if_id_valid_o` output 1: IF/ID holds a real instruction.
- `if_id_pc_o` output XLEN: PC of IF/ID instruction.
- `if_id_pc4_o` output XLEN: that PC + 4.
- `if_id_inst_o` output 32: IF/ID instruction.
- `halted_o` output 1: fetch permanently stopped.

## Operation
- FSM states: RUN, HALT. Reset → RUN.
- RUN: `imem_req_o`=1, `imem_addr_o`=PC (combinational from state/PC).
- Per-cycle priority in RUN: redirect > halt > stall > fetch.
  - redirect_i: PC ← {redirect_pc_i[XLEN-1:2],2'b00}; IF/ID ← bubble (valid 0, inst NOP). Overrides a simultaneous halt_i (halting instruction is younger, flushed) and stall_i.
  - halt_i (no redirect): → HALT; IF/ID ← bubble; PC unchanged.
  - stall_i: PC and IF/ID hold; fetch data this cycle discarded.
  - imem_ready_i: IF/ID ← {valid 1, PC, PC+4, imem_rdata_i}; PC ← PC+4.
  - !imem_ready_i: PC holds; IF/ID ← bubble.
- HALT: `imem_req_o`=0, `halted_o`=1, IF/ID bubble; redirect/stall ignored; exit only by reset.
- PC+4 wraps modulo 2^XLEN (0xFFFF_FFFC → 0x0).
- Bubble: valid 0, inst 32'h0000_0013, pc/pc4 hold previous values.

## Timing
- Reset values: PC=RESET_PC, state RUN, `if_id_valid_o`=0, `if_id_inst_o`=32'h0000_0013, `if_id_pc_o`=0, `if_id_pc4_o`=4, `halted_o`=0, `imem_req_o`=1 after reset deassert.
- Latency: instruction at PC appears on IF/ID one cycle after the cycle in which `imem_ready_i` is high.
- First cycle after `rst_n` rises with ready high: IF/ID holds RESET_PC at the following edge.
- Redirect: target address on `imem_addr_o` the cycle after `redirect_i`; one bubble inserted.
- `halted_o` asserts the cycle after `halt_i`.
- Reset asserted mid-operation (any state, any ready/stall level): all registers return to reset values immediately.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `perf_fetched_o` (32, count of IF/ID loads with valid 1) and `perf_stall_o` (32, count of RUN cycles with stall_i or !imem_ready_i and no redirect); both reset to 0, wrap at 2^32, freeze in HALT.
- Undefined: ports and counters absent; remaining behaviour identical.

## Structure
- Package `fetch_pkg`: state enum (RUN, HALT), `NOP_INST` = 32'h0000_0013, `RESET_PC_DEFAULT`.
- Sub-module `if_id_reg`: IF/ID register with load/hold/bubble controls; FSM and PC logic stay in `fetch_stage`.

## Test plan
- Reset, ready=1, no stall, 4 cycles → IF/ID PCs 0x0,0x4,0x8,0xC, valid 1, inst = memory contents.
- stall_i high 2 cycles at PC 0x8 → IF/ID holds PC 0x4 both cycles; `imem_addr_o` stays 0x8; resumes with 0x8.
- redirect_i with target 0x103 plus stall_i and halt_i same cycle → next addr 0x100, one bubble (valid 0, inst 0x13), state stays RUN.
- halt_i at PC 0x10 → `halted_o`=1 next cycle, `imem_req_o`=0, later redirect to 0x40 ignored; rst_n low → PC=RESET_PC, RUN.
- ready low 3 cycles at PC 0x20 → 3 bubbles, PC held 0x20; with `FETCH_PERF_CNT_EN`, `perf_stall_o` increments by 3.
- PC=0xFFFF_FFFC fetched with ready → `if_id_pc4_o`=0x0, next PC 0x0.
